// File: rtl/lsu_ctrl_if.sv
// Load/store unit bundle: request/response handshake, word-wide memory port and MMIO outputs.
// slave = the LSU itself; master = the core/memory side that drives requests and read data.
interface lsu_ctrl_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [WORD_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_fault;
    logic [WORD_WIDTH-1:0] resp_rdata;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic                  mem_wren;
    logic                  mem_rden;
    logic                  inst_mem_en;
    logic                  data_mem_en;
    logic [3:0]            which_bytes;
    logic [WORD_WIDTH-1:0] mem_data_in;
    logic [WORD_WIDTH-1:0] inst_mem_out;
    logic [WORD_WIDTH-1:0] data_mem_out;
    logic                  stdout_en;
    logic [WORD_WIDTH-1:0] stdout_data;
    logic                  halt;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  inst_mem_out, data_mem_out,
        output req_ready, resp_valid, resp_fault, resp_rdata,
        output mem_addr, mem_wren, mem_rden, inst_mem_en, data_mem_en,
        output which_bytes, mem_data_in, stdout_en, stdout_data, halt
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output inst_mem_out, data_mem_out,
        input  req_ready, resp_valid, resp_fault, resp_rdata,
        input  mem_addr, mem_wren, mem_rden, inst_mem_en, data_mem_en,
        input  which_bytes, mem_data_in, stdout_en, stdout_data, halt
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request in flight, misaligned accesses split into two word beats, console/halt MMIO.
// Store resp 2 cycles (split 3), load 2+MEM_LATENCY (split 3+2*MEM_LATENCY); req_ready low while busy or halted.
module lsu_ctrl #(
    parameter int                    WORD_WIDTH     = 32,
    parameter logic [WORD_WIDTH-1:0] INST_MEM_START = 32'h0001_0000,
    parameter logic [WORD_WIDTH-1:0] DATA_MEM_START = 32'h0002_0000,
    parameter logic [WORD_WIDTH-1:0] DATA_MEM_END   = 32'h0011_FFFF,
    parameter logic [WORD_WIDTH-1:0] STDOUT_ADDR    = 32'h0002_FFF8,
    parameter logic [WORD_WIDTH-1:0] HALT_ADDR      = 32'h0002_FFFC,
    parameter int                    MEM_LATENCY    = 2
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                state_q, state_d;
    logic                  store_q, store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0] rd_lo_q, rd_lo_d;
    logic [WORD_WIDTH-1:0] rd_hi_q, rd_hi_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  halt_q, halt_d;

    function automatic logic in_data(input logic [WORD_WIDTH-1:0] a);
        return (a >= DATA_MEM_START) && (a <= DATA_MEM_END);
    endfunction

    function automatic logic in_inst(input logic [WORD_WIDTH-1:0] a);
        return (a >= INST_MEM_START) && (a < DATA_MEM_START);
    endfunction

    logic [1:0]              off;
    logic [WORD_WIDTH-1:0]   base_addr, next_addr;
    logic [3:0]              size_lanes;
    logic [7:0]              lanes;
    logic [2*WORD_WIDTH-1:0] wdata_sh;
    logic [WORD_WIDTH-1:0]   rd_src, rd_word, rd_ext;
    logic                    f3_ok, split, lo_inst, lo_data, hi_inst, hi_data;
    logic                    fault, is_stdout, is_halt, is_mmio, accept;

    assign off       = addr_q[1:0];
    assign base_addr = {addr_q[WORD_WIDTH-1:2], 2'b00};
    assign next_addr = base_addr + WORD_WIDTH'(4);
    assign f3_ok     = funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    always_comb begin
        size_lanes = 4'b1111;
        case (funct3_q[1:0])
            2'b00:   size_lanes = 4'b0001;
            2'b01:   size_lanes = 4'b0011;
            default: size_lanes = 4'b1111;
        endcase
    end

    // Lanes that spill past byte 3 belong to the second beat, so a split is simply a non-empty upper nibble.
    assign lanes    = {4'b0000, size_lanes} << off;
    assign wdata_sh = {{WORD_WIDTH{1'b0}}, wdata_q} << {off, 3'b000};
    assign split    = (lanes[7:4] != 4'b0000);

    assign lo_inst = in_inst(addr_q);
    assign lo_data = in_data(addr_q);
    assign hi_inst = in_inst(next_addr);
    assign hi_data = in_data(next_addr);

    assign fault = !f3_ok || (store_q && lo_inst) || !(lo_inst || lo_data) ||
                   (split && !((lo_inst && hi_inst) || (lo_data && hi_data)));

    assign is_stdout = store_q && (funct3_q == 3'b010) && (addr_q == STDOUT_ADDR);
    assign is_halt   = store_q && (addr_q == HALT_ADDR);
    assign is_mmio   = is_stdout || is_halt ||
                       (!store_q && ((addr_q == STDOUT_ADDR) || (addr_q == HALT_ADDR)));

    assign rd_src  = lo_inst ? bus.inst_mem_out : bus.data_mem_out;
    assign rd_word = WORD_WIDTH'({rd_hi_q, rd_lo_q} >> {off, 3'b000});

    always_comb begin
        rd_ext = rd_word;
        case (funct3_q)
            3'b000:  rd_ext = {{(WORD_WIDTH-8){rd_word[7]}}, rd_word[7:0]};
            3'b001:  rd_ext = {{(WORD_WIDTH-16){rd_word[15]}}, rd_word[15:0]};
            3'b100:  rd_ext = {{(WORD_WIDTH-8){1'b0}}, rd_word[7:0]};
            3'b101:  rd_ext = {{(WORD_WIDTH-16){1'b0}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_lo_q  <= '0;
            rd_hi_q  <= '0;
            cnt_q    <= 4'd0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_lo_q  <= rd_lo_d;
            rd_hi_q  <= rd_hi_d;
            cnt_q    <= cnt_d;
            halt_q   <= halt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_lo_d  = rd_lo_q;
        rd_hi_d  = rd_hi_q;
        cnt_d    = cnt_q;
        halt_d   = halt_q;
        accept   = 1'b0;

        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_fault  = 1'b0;
        bus.resp_rdata  = '0;
        bus.mem_addr    = '0;
        bus.mem_wren    = 1'b0;
        bus.mem_rden    = 1'b0;
        bus.inst_mem_en = 1'b0;
        bus.data_mem_en = 1'b0;
        bus.which_bytes = 4'b0000;
        bus.mem_data_in = '0;
        bus.stdout_en   = 1'b0;
        bus.stdout_data = '0;
        bus.halt        = halt_q;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = !halt_q && !rst;
                accept        = bus.req_valid && !halt_q && !rst;
                if (accept) begin
                    store_d  = bus.req_is_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rd_lo_d  = '0;
                    rd_hi_d  = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (fault) begin
                    state_d = RESP;
                end else if (is_mmio) begin
                    bus.stdout_en   = is_stdout;
                    bus.stdout_data = is_stdout ? wdata_q : '0;
                    halt_d          = halt_q || is_halt;
                    state_d         = RESP;
                end else begin
                    bus.mem_addr    = base_addr;
                    bus.which_bytes = lanes[3:0];
                    bus.inst_mem_en = lo_inst;
                    bus.data_mem_en = lo_data;
                    bus.mem_wren    = store_q;
                    bus.mem_rden    = !store_q;
                    bus.mem_data_in = store_q ? wdata_sh[WORD_WIDTH-1:0] : '0;
                    cnt_d           = LAT_LOAD;
                    state_d         = store_q ? (split ? ISSUE2 : RESP) : WAIT;
                end
            end
            WAIT: begin
                bus.mem_addr    = base_addr;
                bus.which_bytes = lanes[3:0];
                bus.inst_mem_en = lo_inst;
                bus.data_mem_en = lo_data;
                if (cnt_q == 4'd0) begin
                    rd_lo_d = rd_src;
                    state_d = split ? ISSUE2 : RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ISSUE2: begin
                bus.mem_addr    = next_addr;
                bus.which_bytes = lanes[7:4];
                bus.inst_mem_en = lo_inst;
                bus.data_mem_en = lo_data;
                bus.mem_wren    = store_q;
                bus.mem_rden    = !store_q;
                bus.mem_data_in = store_q ? wdata_sh[2*WORD_WIDTH-1:WORD_WIDTH] : '0;
                cnt_d           = LAT_LOAD;
                state_d         = store_q ? RESP : WAIT2;
            end
            WAIT2: begin
                bus.mem_addr    = next_addr;
                bus.which_bytes = lanes[7:4];
                bus.inst_mem_en = lo_inst;
                bus.data_mem_en = lo_data;
                if (cnt_q == 4'd0) begin
                    rd_hi_d = rd_src;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_fault = fault;
                bus.resp_rdata = (fault || store_q || is_mmio) ? '0 : rd_ext;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: latency-accurate memory model returns data only in the valid cycle.
module tb_lsu_ctrl;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.WORD_WIDTH(32)) bus ();

    lsu_ctrl #(.WORD_WIDTH(32), .MEM_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Read data is valid only MEM_LATENCY cycles after the rden cycle; garbage otherwise.
    logic        pv [L];
    logic [31:0] pa [L];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 32'h0;
            end
        end else begin
            for (int i = L - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            pv[0] <= bus.mem_rden;
            pa[0] <= bus.mem_addr;
        end
    end

    function automatic logic [31:0] dmem(input logic [31:0] a);
        case (a)
            32'h0002_0004: return 32'h80FF_1234;
            32'h0002_0008: return 32'h5566_7788;
            default:       return a ^ 32'h0F0F_0F0F;
        endcase
    endfunction

    assign bus.data_mem_out = pv[L-1] ? dmem(pa[L-1]) : 32'hDEAD_BEEF;
    assign bus.inst_mem_out = pv[L-1] ? 32'h0000_0513 : 32'hDEAD_BEEF;

    int          n_checks, n_errors;
    int          r_cyc, n_beats, n_rd, n_wr, n_std, n_inst, n_data;
    logic [31:0] r_rdata, std_data;
    logic        r_fault, r_halt;
    logic [31:0] b_addr [2];
    logic [31:0] b_data [2];
    logic [3:0]  b_lanes [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b111;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'hFFFF_FFFF;
    endtask

    // Issues one request and records everything seen until the response (cycle 1 = first cycle after acceptance).
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        r_cyc = 0; n_beats = 0; n_rd = 0; n_wr = 0; n_std = 0; n_inst = 0; n_data = 0;
        r_rdata = 32'hxxxx_xxxx; std_data = 32'h0; r_fault = 1'bx; r_halt = 1'bx;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = 32'h0; b_data[i] = 32'h0; b_lanes[i] = 4'h0;
        end
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
        if (!bus.req_ready) return;
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        idle_inputs();
        bus.req_is_store = ~st;
        for (int c = 1; c <= 40; c++) begin
            if (bus.mem_rden) n_rd++;
            if (bus.mem_wren) n_wr++;
            if (bus.mem_rden || bus.mem_wren) begin
                if (n_beats < 2) begin
                    b_addr[n_beats]  = bus.mem_addr;
                    b_lanes[n_beats] = bus.which_bytes;
                    b_data[n_beats]  = bus.mem_data_in;
                end
                n_beats++;
            end
            if (bus.inst_mem_en) n_inst++;
            if (bus.data_mem_en) n_data++;
            if (bus.stdout_en) begin
                n_std++;
                std_data = bus.stdout_data;
            end
            if (bus.resp_valid) begin
                r_cyc   = c;
                r_rdata = bus.resp_rdata;
                r_fault = bus.resp_fault;
                r_halt  = bus.halt;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_resp_seen"}, 32'(r_cyc != 0), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_resp_pulse"}, 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic expect_resp(input string tag, input int cyc, input logic [31:0] rdata, input logic fault);
        check({tag, "_cyc"}, cyc, r_cyc);
        check({tag, "_rdata"}, r_rdata, rdata);
        check({tag, "_fault"}, 32'(r_fault), 32'(fault));
    endtask

    task automatic expect_beat(input string tag, input int idx, input logic [31:0] addr,
                               input logic [3:0] lanes_e);
        check({tag, "_addr"}, b_addr[idx], addr);
        check({tag, "_lanes"}, 32'(b_lanes[idx]), 32'(lanes_e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_flags", 32'({bus.resp_valid, bus.resp_fault, bus.mem_wren, bus.mem_rden,
                                bus.inst_mem_en, bus.data_mem_en, bus.stdout_en, bus.halt}), 32'd0);
        check("rst_bus", bus.mem_addr | bus.mem_data_in | bus.resp_rdata | bus.stdout_data |
                         32'(bus.which_bytes), 32'd0);

        // Aligned word load from data memory
        do_req("lw", 1'b0, 3'b010, 32'h0002_0004, 32'h0);
        expect_resp("lw", 4, 32'h80FF_1234, 1'b0);
        expect_beat("lw_b1", 0, 32'h0002_0004, 4'b1111);
        check("lw_nrd", n_rd, 1);
        check("lw_nwr", n_wr, 0);

        do_req("lb", 1'b0, 3'b000, 32'h0002_0007, 32'h0);
        expect_resp("lb", 4, 32'hFFFF_FF80, 1'b0);
        expect_beat("lb_b1", 0, 32'h0002_0004, 4'b1000);

        do_req("lbu", 1'b0, 3'b100, 32'h0002_0007, 32'h0);
        expect_resp("lbu", 4, 32'h0000_0080, 1'b0);

        do_req("lh", 1'b0, 3'b001, 32'h0002_0006, 32'h0);
        expect_resp("lh", 4, 32'hFFFF_80FF, 1'b0);
        expect_beat("lh_b1", 0, 32'h0002_0004, 4'b1100);
        check("lh_nrd", n_rd, 1);

        // Split word store
        do_req("sw_split", 1'b1, 3'b010, 32'h0002_0006, 32'hAABB_CCDD);
        expect_resp("sw_split", 3, 32'h0, 1'b0);
        expect_beat("sw_split_b1", 0, 32'h0002_0004, 4'b1100);
        expect_beat("sw_split_b2", 1, 32'h0002_0008, 4'b0011);
        check("sw_split_d1", b_data[0], 32'hCCDD_0000);
        check("sw_split_d2", b_data[1], 32'h0000_AABB);
        check("sw_split_nwr", n_wr, 2);
        check("sw_split_nrd", n_rd, 0);

        // Split loads: {0x55667788, 0x80FF1234} shifted right by the byte offset
        do_req("lw_split", 1'b0, 3'b010, 32'h0002_0006, 32'h0);
        expect_resp("lw_split", 7, 32'h7788_80FF, 1'b0);
        expect_beat("lw_split_b1", 0, 32'h0002_0004, 4'b1100);
        expect_beat("lw_split_b2", 1, 32'h0002_0008, 4'b0011);
        check("lw_split_nrd", n_rd, 2);

        do_req("lh_split", 1'b0, 3'b001, 32'h0002_0007, 32'h0);
        expect_resp("lh_split", 7, 32'hFFFF_8880, 1'b0);
        expect_beat("lh_split_b1", 0, 32'h0002_0004, 4'b1000);
        expect_beat("lh_split_b2", 1, 32'h0002_0008, 4'b0001);

        do_req("lhu_split", 1'b0, 3'b101, 32'h0002_0007, 32'h0);
        expect_resp("lhu_split", 7, 32'h0000_8880, 1'b0);

        do_req("sb", 1'b1, 3'b000, 32'h0002_0001, 32'h0000_005A);
        expect_resp("sb", 2, 32'h0, 1'b0);
        expect_beat("sb_b1", 0, 32'h0002_0000, 4'b0010);
        check("sb_data", b_data[0], 32'h0000_5A00);

        // Instruction region load
        do_req("lw_inst", 1'b0, 3'b010, 32'h0001_0000, 32'h0);
        expect_resp("lw_inst", 4, 32'h0000_0513, 1'b0);
        check("lw_inst_ien", 32'(n_inst != 0), 32'd1);
        check("lw_inst_den", n_data, 0);

        // Console MMIO
        do_req("stdout", 1'b1, 3'b010, 32'h0002_FFF8, 32'h0000_0041);
        expect_resp("stdout", 2, 32'h0, 1'b0);
        check("stdout_n", n_std, 1);
        check("stdout_data", std_data, 32'h0000_0041);
        check("stdout_strobes", n_wr + n_rd + n_data + n_inst, 0);

        do_req("mmio_ld", 1'b0, 3'b010, 32'h0002_FFF8, 32'h0);
        check("mmio_ld_rdata", r_rdata, 32'h0);
        check("mmio_ld_fault", 32'(r_fault), 32'd0);
        check("mmio_ld_rd", n_rd, 0);

        // Faults
        do_req("sw_inst", 1'b1, 3'b010, 32'h0001_0000, 32'h1234_5678);
        expect_resp("sw_inst", 2, 32'h0, 1'b1);
        check("sw_inst_strobes", n_wr + n_rd + n_data + n_inst, 0);

        do_req("lw_unmap", 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        expect_resp("lw_unmap", 2, 32'h0, 1'b1);
        check("lw_unmap_strobes", n_wr + n_rd + n_data + n_inst, 0);

        do_req("bad_f3", 1'b0, 3'b011, 32'h0002_0004, 32'h0);
        expect_resp("bad_f3", 2, 32'h0, 1'b1);

        do_req("cross", 1'b0, 3'b010, 32'h0001_FFFE, 32'h0);
        expect_resp("cross", 2, 32'h0, 1'b1);
        check("cross_strobes", n_wr + n_rd + n_data + n_inst, 0);

        // Reset while a load waits for memory
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b010;
        bus.req_addr     = 32'h0002_0004;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_flags", 32'({bus.resp_valid, bus.resp_fault, bus.mem_wren, bus.mem_rden,
                                 bus.inst_mem_en, bus.data_mem_en, bus.stdout_en, bus.halt}), 32'd0);
        check("arst_bus", bus.mem_addr | 32'(bus.which_bytes), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("arst_noresp", 32'(bus.resp_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("arst_stale", 32'(bus.resp_valid), 32'd0);
        end
        do_req("lw_after", 1'b0, 3'b010, 32'h0002_0004, 32'h0);
        expect_resp("lw_after", 4, 32'h80FF_1234, 1'b0);

        // Halt MMIO is sticky until reset
        do_req("halt", 1'b1, 3'b010, 32'h0002_FFFC, 32'h0000_0001);
        expect_resp("halt", 2, 32'h0, 1'b0);
        check("halt_at_resp", 32'(r_halt), 32'd1);
        check("halt_strobes", n_wr + n_data, 0);
        repeat (3) @(posedge clk);
        #1;
        check("halt_hold", 32'(bus.halt), 32'd1);
        check("halt_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("halt_rst", 32'(bus.halt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("halt_rst_ready", 32'(bus.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter INST_MEM_START, default 32'h00010000, lowest instruction-region byte address.
REQ-003 SHALL have parameter DATA_MEM_START, default 32'h00020000, lowest data-region byte address.
REQ-004 SHALL have parameter DATA_MEM_END, default 32'h0011FFFF, highest mapped byte address.
REQ-005 SHALL have parameter STDOUT_ADDR, default 32'h0002FFF8, console MMIO word.
REQ-006 SHALL have parameter HALT_ADDR, default 32'h0002FFFC, halt MMIO word.
REQ-007 SHALL have parameter MEM_LATENCY, default 2, range 1..8, cycles from the mem_rden cycle to valid read data.
REQ-008 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in / out  1  request handshake.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr, req_wdata  in  WORD_WIDTH  byte address; store data, LSB-aligned.
- resp_valid, resp_fault  out  1  completion pulse; illegal-access flag.
- resp_rdata  out  WORD_WIDTH  extended load result (0 for stores/faults).
- mem_addr  out  WORD_WIDTH  word-aligned address, bits [1:0] = 0.
- mem_wren, mem_rden, inst_mem_en, data_mem_en  out  1  memory strobes.
- which_bytes  out  4  byte-lane enables for the current beat.
- mem_data_in  out  WORD_WIDTH  lane-shifted write data.
- inst_mem_out, data_mem_out  in  WORD_WIDTH  read data.
- stdout_en  out  1; stdout_data  out  WORD_WIDTH  console write.
- halt  out  1  sticky halt.

Function
REQ-009 SHALL accept a request on a rising edge with req_valid && req_ready; req_ready = 1 only in IDLE with halt = 0.
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP; one request in flight.
REQ-011 SHALL register all request fields at acceptance; later input changes have no effect.
REQ-012 SHALL classify: data region [DATA_MEM_START, DATA_MEM_END] -> data_mem_en; instruction region [INST_MEM_START, DATA_MEM_START) -> inst_mem_en, loads only; anything else, stores to instruction region, or undefined funct3 -> fault.
REQ-013 SHALL, on fault, assert no strobe, go IDLE->ISSUE->RESP, and give resp_fault = 1, resp_rdata = 0.
REQ-014 SHALL treat a word store to STDOUT_ADDR as MMIO: no memory strobe; stdout_en = 1 for the single ISSUE cycle with stdout_data = req_wdata.
REQ-015 SHALL treat any store to HALT_ADDR as MMIO: halt goes 1 at the end of ISSUE and holds until reset.
REQ-016 SHALL return resp_rdata = 0 with no fault for loads from MMIO addresses.
REQ-017 SHALL assert mem_rden/mem_wren for exactly one cycle per beat (ISSUE or ISSUE2).
REQ-018 SHALL shift which_bytes and mem_data_in left by req_addr[1:0] lanes for the first beat.
REQ-019 SHALL handle a misaligned access (half at offset 3, word at offset 1..3) as two beats: beat 1 at the aligned word, beat 2 at aligned word + 4 with the remaining low lanes.
REQ-020 SHALL require both beats of a split access to be in the same region; otherwise the access faults and no beat issues.
REQ-021 SHALL wait MEM_LATENCY cycles after each load beat (WAIT/WAIT2, down-counter) and capture read data at the end of the last wait cycle.
REQ-022 SHALL merge split-load bytes, then zero-extend (BU/HU) or sign-extend (B/H) into resp_rdata.
REQ-023 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE.
REQ-024 SHALL give these latencies from the acceptance edge: aligned store = resp_valid in cycle 2; aligned load = cycle 2+MEM_LATENCY; split store = cycle 3; split load = cycle 3+2*MEM_LATENCY.

Reset
REQ-025 SHALL on rst: state IDLE, halt = 0, every other output 0 (req_ready 1 after release), counters cleared.
REQ-026 SHALL abandon any in-flight access on reset with no response.

Verification
REQ-027 LW at 0x00020004, data_mem_out = 0x80FF1234, MEM_LATENCY 2 -> mem_rden 1 cycle at 0x00020004, which_bytes 1111, resp_rdata 0x80FF1234 in cycle 4.
REQ-028 LB at 0x00020007, data_mem_out = 0x80FF1234 -> which_bytes 1000, resp_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-029 SW 0xAABBCCDD at 0x00020006 -> beat 1 at 0x00020004, lanes 1100, data 0xCCDD0000; beat 2 at 0x00020008, lanes 0011, data 0x0000AABB; resp_valid in cycle 3.
REQ-030 SW 0x41 at 0x0002FFF8 -> stdout_en 1 cycle with 0x41, no mem_wren; SW at 0x0002FFFC -> halt = 1, req_ready = 0 until rst.
REQ-031 SW at 0x00010000 or LW at 0x00000010 -> resp_fault = 1 in cycle 2, no strobes.
REQ-032 rst asserted during WAIT of a load -> all outputs 0 immediately, no resp_valid; a new LW after release completes normally.
